// File: rtl/lector_display_hexadecimal.sv
// Readback of a multiplexed common-anode 7-segment bus.
// The {anodes,segments} bus is brought into the clock domain, qualified by a
// stability counter, and each stable single-digit pattern is decoded back
// into its hex nibble. A frame mask tracks which digits have been seen so a
// pulse can mark every completed scan.
module lector_display_hexadecimal #(
    parameter int NUM_DIGITOS = 4,
    parameter int ESTABLE     = 4
) (
    input  logic                       Reloj,
    input  logic                       Reset,
    input  logic                       Habilitar,
    input  logic [6:0]                 Segmentos,
    input  logic [NUM_DIGITOS-1:0]     Anodos,
    output logic [4*NUM_DIGITOS-1:0]   Binario,
    output logic [NUM_DIGITOS-1:0]     DigitoValido,
    output logic                       Actualizado,
    output logic                       Error
);

    localparam int CW = $clog2(ESTABLE);
    localparam logic [CW-1:0] CNT_MAX = CW'(ESTABLE - 1);
    localparam logic [6:0] APAGADO = 7'b1111111;

    typedef struct packed {
        logic [NUM_DIGITOS-1:0] anodos;
        logic [6:0]             segmentos;
    } muestra_t;

    typedef enum logic [1:0] {
        ESPERA    = 2'd0,
        CONTANDO  = 2'd1,
        CAPTURADO = 2'd2
    } estado_t;

    // Glyph lookup; bit 4 flags a hit in the hex table.
    function automatic logic [4:0] decodificar(input logic [6:0] s);
        case (s)
            7'b1000000: decodificar = {1'b1, 4'h0};
            7'b1111001: decodificar = {1'b1, 4'h1};
            7'b0100100: decodificar = {1'b1, 4'h2};
            7'b0110000: decodificar = {1'b1, 4'h3};
            7'b0011001: decodificar = {1'b1, 4'h4};
            7'b0010010: decodificar = {1'b1, 4'h5};
            7'b0000010: decodificar = {1'b1, 4'h6};
            7'b1111000: decodificar = {1'b1, 4'h7};
            7'b0000000: decodificar = {1'b1, 4'h8};
            7'b0011000: decodificar = {1'b1, 4'h9};
            7'b0001000: decodificar = {1'b1, 4'hA};
            7'b0000011: decodificar = {1'b1, 4'hB};
            7'b1000110: decodificar = {1'b1, 4'hC};
            7'b0100001: decodificar = {1'b1, 4'hD};
            7'b0000110: decodificar = {1'b1, 4'hE};
            7'b0001110: decodificar = {1'b1, 4'hF};
            default:    decodificar = 5'b0_0000;
        endcase
    endfunction

    muestra_t entrada;
    muestra_t sinc1, sinc2, previo;
    logic     cambio;

    logic [CW-1:0] cuenta;
    estado_t       estado, estado_sig;
    logic          captura;

    logic [NUM_DIGITOS-1:0] anodos_act;
    logic                   ninguno, varios, uno;
    logic [4:0]             deco;
    logic                   acierto, apagado, glifo_ilegal;
    logic [NUM_DIGITOS-1:0] sel;
    logic [NUM_DIGITOS-1:0] mascara, mascara_nueva;
    logic                   completo, fallo;

    assign entrada = {Anodos, Segmentos};
    assign cambio  = (sinc2 != previo);

    // Two-flop synchroniser plus the compare register; all reset to blank so
    // an idle bus after reset is not seen as a change.
    always_ff @(posedge Reloj or posedge Reset) begin
        if (Reset) begin
            sinc1  <= '1;
            sinc2  <= '1;
            previo <= '1;
        end else begin
            sinc1  <= entrada;
            sinc2  <= sinc1;
            previo <= sinc2;
        end
    end

    // Stability counter: restarts on any change or while disabled, saturates.
    always_ff @(posedge Reloj or posedge Reset) begin
        if (Reset)
            cuenta <= '0;
        else if (cambio || !Habilitar)
            cuenta <= '0;
        else if (cuenta != CNT_MAX)
            cuenta <= cuenta + 1'b1;
    end

    // State register.
    always_ff @(posedge Reloj or posedge Reset) begin
        if (Reset)
            estado <= ESPERA;
        else
            estado <= estado_sig;
    end

    // Next state; a capture fires once per stable pattern.
    always_comb begin
        estado_sig = estado;
        captura    = 1'b0;
        if (!Habilitar) begin
            estado_sig = ESPERA;
        end else begin
            case (estado)
                ESPERA: begin
                    if (cambio)
                        estado_sig = CONTANDO;
                end
                CONTANDO: begin
                    if (!cambio && cuenta == CNT_MAX) begin
                        captura    = 1'b1;
                        estado_sig = CAPTURADO;
                    end
                end
                CAPTURADO: begin
                    if (cambio)
                        estado_sig = CONTANDO;
                end
                default: estado_sig = ESPERA;
            endcase
        end
    end

    // Classify the captured pattern: which digit, whether the glyph is legal,
    // and whether this capture completes the frame.
    always_comb begin
        anodos_act    = ~previo.anodos;
        ninguno       = (anodos_act == '0);
        varios        = ($countones(anodos_act) > 1);
        uno           = !ninguno && !varios;
        deco          = decodificar(previo.segmentos);
        acierto       = deco[4];
        apagado       = (previo.segmentos == APAGADO);
        glifo_ilegal  = !acierto && !apagado;
        sel           = (captura && uno) ? anodos_act : '0;
        mascara_nueva = mascara | sel;
        completo      = captura && uno && (mascara_nueva == '1);
        fallo         = captura && (varios || (uno && glifo_ilegal));
    end

    // Frame mask: cleared while disabled and on the completing capture.
    always_ff @(posedge Reloj or posedge Reset) begin
        if (Reset)
            mascara <= '0;
        else if (!Habilitar || completo)
            mascara <= '0;
        else
            mascara <= mascara_nueva;
    end

    // Per-digit result registers; a blank or illegal glyph keeps the nibble.
    always_ff @(posedge Reloj or posedge Reset) begin
        if (Reset) begin
            Binario      <= '0;
            DigitoValido <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITOS; i++) begin
                if (sel[i]) begin
                    DigitoValido[i] <= acierto;
                    if (acierto)
                        Binario[4*i +: 4] <= deco[3:0];
                end
            end
        end
    end

    // Event pulses, one cycle each.
    always_ff @(posedge Reloj or posedge Reset) begin
        if (Reset) begin
            Actualizado <= 1'b0;
            Error       <= 1'b0;
        end else begin
            Actualizado <= completo;
            Error       <= fallo;
        end
    end

endmodule

// File: tb/tb_lector_display_hexadecimal.sv
// Bench for lector_display_hexadecimal: a run-level reference model predicts
// every observable output event, a monitor matches the DUT against it.
module tb_lector_display_hexadecimal;

    localparam int ND  = 4;
    localparam int EST = 4;

    logic            Reloj, Reset, Habilitar;
    logic [6:0]      Segmentos;
    logic [ND-1:0]   Anodos;
    logic [4*ND-1:0] Binario;
    logic [ND-1:0]   DigitoValido;
    logic            Actualizado, Error;

    lector_display_hexadecimal #(.NUM_DIGITOS(ND), .ESTABLE(EST)) dut (
        .Reloj(Reloj), .Reset(Reset), .Habilitar(Habilitar),
        .Segmentos(Segmentos), .Anodos(Anodos),
        .Binario(Binario), .DigitoValido(DigitoValido),
        .Actualizado(Actualizado), .Error(Error)
    );

    initial begin
        Reloj = 1'b0;
        forever #5 Reloj = ~Reloj;
    end

    int cyc = 0;
    initial forever @(posedge Reloj) cyc++;

    typedef struct {
        int              ciclo;
        logic [4*ND-1:0] bin;
        logic [ND-1:0]   val;
        logic            act;
        logic            err;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;

    logic [6:0] glifo [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference state
    logic [3:0]    m_nib [ND];
    logic [ND-1:0] m_val;
    logic [ND-1:0] m_mask;
    logic [ND+6:0] last;
    int            run_start, run_len;
    bit            run_done;
    bit            m_hab;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [4*ND-1:0] m_bin();
        logic [4*ND-1:0] b;
        for (int i = 0; i < ND; i++) b[4*i +: 4] = m_nib[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) m_nib[i] = 4'h0;
        m_val    = '0;
        m_mask   = '0;
        last     = '1;
        run_done = 1'b1;
        run_len  = 0;
    endtask

    // Effect of one capture of a stable {an,sg} pattern on edge ed.
    task automatic model_capture(input logic [ND-1:0] an, input logic [6:0] sg, input int ed);
        ev_t e;
        logic [4*ND-1:0] b0;
        logic [ND-1:0]   v0;
        int low, dig, idx;
        b0 = m_bin();
        v0 = m_val;
        e.act = 1'b0;
        e.err = 1'b0;
        low = 0;
        dig = 0;
        for (int i = 0; i < ND; i++)
            if (!an[i]) begin low++; dig = i; end
        if (low > 1) begin
            e.err = 1'b1;
        end else if (low == 1) begin
            idx = -1;
            for (int j = 0; j < 16; j++) if (glifo[j] == sg) idx = j;
            if (idx >= 0) begin
                m_nib[dig] = 4'(idx);
                m_val[dig] = 1'b1;
            end else begin
                m_val[dig] = 1'b0;
                if (sg != 7'h7F) e.err = 1'b1;
            end
            m_mask[dig] = 1'b1;
            if (m_mask == '1) begin
                e.act  = 1'b1;
                m_mask = '0;
            end
        end
        e.ciclo = ed;
        e.bin   = m_bin();
        e.val   = m_val;
        if (e.act || e.err || e.bin != b0 || e.val != v0) q.push_back(e);
    endtask

    // Hold {an,sg} on the pins for d samples. A run of equal values is one
    // stable pattern; it is captured once it has lasted EST+1 samples,
    // EST+2 edges after its first sample.
    task automatic drive(input logic [ND-1:0] an, input logic [6:0] sg, input int d);
        if ({an, sg} == last) begin
            run_len += d;
        end else begin
            last      = {an, sg};
            run_start = cyc + 1;
            run_len   = d;
            run_done  = !m_hab;
        end
        if (!run_done && run_len >= EST + 1) begin
            model_capture(an, sg, run_start + EST + 2);
            run_done = 1'b1;
        end
        Anodos    = an;
        Segmentos = sg;
        repeat (d) @(posedge Reloj);
        #1;
    endtask

    // Only called while the bus sits blank and settled.
    task automatic set_hab(input bit v);
        Habilitar = v;
        m_hab     = v;
        if (!v) m_mask = '0;
        run_done = 1'b1;
        @(posedge Reloj);
        #1;
    endtask

    // Monitor: every observable change or pulse must match the next expected event.
    initial begin
        logic [4*ND-1:0] pb;
        logic [ND-1:0]   pv;
        ev_t e;
        pb = '0;
        pv = '0;
        forever begin
            @(negedge Reloj);
            if (Reset) begin
                pb = '0;
                pv = '0;
            end else if (Actualizado || Error || Binario != pb || DigitoValido != pv) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d bin=%h val=%b act=%b err=%b",
                             cyc, Binario, DigitoValido, Actualizado, Error);
                end else begin
                    e = q.pop_front();
                    chk("ev_cycle", cyc, e.ciclo);
                    chk("ev_binario", 32'(Binario), 32'(e.bin));
                    chk("ev_valido", 32'(DigitoValido), 32'(e.val));
                    chk("ev_actualizado", 32'(Actualizado), 32'(e.act));
                    chk("ev_error", 32'(Error), 32'(e.err));
                end
                pb = Binario;
                pv = DigitoValido;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
        $fatal(1, "timeout");
    end

    initial begin
        logic [ND-1:0] an;
        logic [6:0]    sg;
        int r, d;

        Reset     = 1'b1;
        Habilitar = 1'b1;
        m_hab     = 1'b1;
        Anodos    = '1;
        Segmentos = 7'h7F;
        model_reset();
        #2;
        chk("rst_binario", 32'(Binario), 0);
        chk("rst_valido", 32'(DigitoValido), 0);
        chk("rst_act", 32'(Actualizado), 0);
        chk("rst_err", 32'(Error), 0);
        repeat (2) @(posedge Reloj);
        #1;
        Reset = 1'b0;

        // Idle blank bus
        drive('1, 7'h7F, 20);

        // Single digit, then the rest of the hold brings nothing new
        drive(4'b1110, 7'b0100100, 12);

        // Two full scans A,B,C,D
        for (int s = 0; s < 2; s++) begin
            drive(4'b1110, 7'b0001000, 10);
            drive(4'b1101, 7'b0000011, 10);
            drive(4'b1011, 7'b1000110, 10);
            drive(4'b0111, 7'b0100001, 10);
        end
        chk("scan_binario", 32'(Binario), 32'h0000DCBA);

        // Glitch rejection
        drive(4'b1101, 7'b1111001, 2);
        drive(4'b1101, 7'b0110000, 10);

        // Illegal glyph, two anodes low, blank digit
        drive(4'b1011, 7'b0101010, 10);
        drive(4'b1100, 7'b0010010, 10);
        drive(4'b1011, 7'h7F, 10);

        // Disabled scan, then re-enable mid-scan
        drive('1, 7'h7F, 10);
        set_hab(1'b0);
        for (int i = 0; i < ND; i++) drive(~(4'b0001 << i), 7'b0010010, 10);
        drive('1, 7'h7F, 10);
        set_hab(1'b1);
        drive(4'b1011, 7'b0011001, 10);
        drive(4'b0111, 7'b0000010, 10);
        drive(4'b1110, 7'b1111000, 10);
        drive(4'b1101, 7'b0000000, 10);
        drive(4'b1011, 7'b0011000, 10);

        // Asynchronous reset in the middle of a count
        drive('1, 7'h7F, 10);
        chk("queue_before_reset", q.size(), 0);
        Anodos    = 4'b1110;
        Segmentos = 7'b0100100;
        repeat (3) @(posedge Reloj);
        #3;
        Reset = 1'b1;
        #1;
        chk("async_binario", 32'(Binario), 0);
        chk("async_valido", 32'(DigitoValido), 0);
        chk("async_act", 32'(Actualizado), 0);
        chk("async_err", 32'(Error), 0);
        Anodos    = '1;
        Segmentos = 7'h7F;
        repeat (2) @(posedge Reloj);
        #1;
        Reset = 1'b0;
        model_reset();

        // Randomised bus traffic
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                an = ~(4'b0001 << $urandom_range(0, ND - 1));
            end else if (r < 8) begin
                an = '1;
            end else begin
                do an = 4'($urandom); while ($countones(~an) < 2);
            end
            r = $urandom_range(0, 9);
            if (r < 7)      sg = glifo[$urandom_range(0, 15)];
            else if (r < 8) sg = 7'h7F;
            else            sg = 7'($urandom);
            d = $urandom_range(1, 12);
            drive(an, sg, d);
        end

        drive('1, 7'h7F, 12);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
